// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive bit-timing slice.
// Legal oversampling ratios, counter widths and the 3-input majority vote.
package uart_rx_pkg;

    localparam int PRESCALE_W = 6;
    localparam int EDGE_W     = 5;
    localparam int BIT_W      = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8       = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16      = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32      = 6'd32;
    localparam logic [PRESCALE_W-1:0] DEFAULT_PRESCALE = PRESCALE_8;

    localparam logic [BIT_W-1:0] BIT_START = 4'd1;
    localparam logic [BIT_W-1:0] BIT_MAX   = 4'd15;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Mid-bit 3-sample majority vote; sampled_bit/sample_valid appear at edge half+2.
// Latency: vote registered at edge half+1; no backpressure, strobe is fire-and-forget.
module uart_rx_data_sampling
    import uart_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              counter_enable,
    input  logic              data_sample_en,
    input  logic [EDGE_W-1:0] edge_count,
    input  logic [EDGE_W-1:0] half,
    output logic              sampled_bit,
    output logic              sample_valid
);

    logic              r_s0;
    logic              r_s1;
    logic              r_v0;
    logic              r_v1;
    logic              r_sampled_bit;
    logic              r_sample_valid;
    logic [EDGE_W-1:0] w_half_m1;
    logic [EDGE_W-1:0] w_half_p1;

    assign w_half_m1 = half - 1'b1;
    assign w_half_p1 = half + 1'b1;

    // r_v0/r_v1 remember that the sampling window was enabled, so a gap in
    // data_sample_en at any of the three edges suppresses the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0           <= 1'b0;
            r_s1           <= 1'b0;
            r_v0           <= 1'b0;
            r_v1           <= 1'b0;
            r_sampled_bit  <= 1'b1;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (!counter_enable || edge_count == '0) begin
                r_s0 <= 1'b0;
                r_s1 <= 1'b0;
                r_v0 <= 1'b0;
                r_v1 <= 1'b0;
            end else begin
                if (edge_count == w_half_m1) begin
                    r_s0 <= rx;
                    r_v0 <= data_sample_en;
                end
                if (edge_count == half) begin
                    r_s1 <= rx;
                    r_v1 <= data_sample_en;
                end
                if (edge_count == w_half_p1 && data_sample_en && r_v0 && r_v1) begin
                    r_sampled_bit  <= maj3(r_s0, r_s1, rx);
                    r_sample_valid <= 1'b1;
                end
            end
        end
    end

    assign sampled_bit  = r_sampled_bit;
    assign sample_valid = r_sample_valid;

endmodule

// File: rtl/uart_rx_timing.sv
// UART RX bit timing: prescale capture, edge/bit counters, majority-vote sampler.
// Counters update every cycle, sample strobe at edge half+2, no backpressure; UART_RX_SYNC_EN adds a 2-flop RX synchronizer.
module uart_rx_timing
    import uart_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  counter_enable,
    input  logic                  data_sample_en,
    output logic [EDGE_W-1:0]     edge_count,
    output logic [BIT_W-1:0]      bit_count,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  prescale_err
);

    logic [PRESCALE_W-1:0] r_prescale_q;
    logic                  r_prescale_err;
    logic [EDGE_W-1:0]     r_edge_count;
    logic [BIT_W-1:0]      r_bit_count;
    logic                  w_rx;
    logic                  w_wrap;
    logic [EDGE_W-1:0]     w_half;

`ifdef UART_RX_SYNC_EN
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX_IN;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx = r_rx_sync;
`else
    assign w_rx = RX_IN;
`endif

    assign w_wrap = ({1'b0, r_edge_count} == (r_prescale_q - 1'b1));
    assign w_half = r_prescale_q[PRESCALE_W-1:1];

    // Prescale is only sampled between frames so a frame keeps one bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale_q   <= DEFAULT_PRESCALE;
            r_prescale_err <= 1'b0;
        end else if (!counter_enable) begin
            if (prescale_legal(Prescale)) begin
                r_prescale_q   <= Prescale;
                r_prescale_err <= 1'b0;
            end else begin
                r_prescale_q   <= DEFAULT_PRESCALE;
                r_prescale_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_count <= '0;
            r_bit_count  <= BIT_START;
        end else if (!counter_enable) begin
            r_edge_count <= '0;
            r_bit_count  <= BIT_START;
        end else if (w_wrap) begin
            r_edge_count <= '0;
            if (r_bit_count != BIT_MAX) begin
                r_bit_count <= r_bit_count + 1'b1;
            end
        end else begin
            r_edge_count <= r_edge_count + 1'b1;
        end
    end

    uart_rx_data_sampling u_sampling (
        .clk            (clk),
        .rst            (rst),
        .rx             (w_rx),
        .counter_enable (counter_enable),
        .data_sample_en (data_sample_en),
        .edge_count     (r_edge_count),
        .half           (w_half),
        .sampled_bit    (sampled_bit),
        .sample_valid   (sample_valid)
    );

    assign edge_count   = r_edge_count;
    assign bit_count    = r_bit_count;
    assign prescale_err = r_prescale_err;

endmodule

// File: tb/tb_uart_rx_timing.sv
// Directed self-checking bench for uart_rx_timing (default build, RX sampled directly).
module tb_uart_rx_timing;

    logic       clk;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       counter_enable;
    logic       data_sample_en;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       sample_valid;
    logic       prescale_err;

    int vectors     = 0;
    int miscompares = 0;
    int strobes     = 0;

    logic [9:0] frame_bits;

    uart_rx_timing dut (
        .clk            (clk),
        .rst            (rst),
        .RX_IN          (RX_IN),
        .Prescale       (Prescale),
        .counter_enable (counter_enable),
        .data_sample_en (data_sample_en),
        .edge_count     (edge_count),
        .bit_count      (bit_count),
        .sampled_bit    (sampled_bit),
        .sample_valid   (sample_valid),
        .prescale_err   (prescale_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One bit period starting at edge_count==0; r0/r1/r2 drive the three vote edges.
    task automatic bit_cycle(input int pq, input logic r0, input logic r1, input logic r2,
                             input logic rest, input logic exp_bit, input int exp_bc);
        int h;
        h = pq / 2;
        for (int i = 0; i < pq; i++) begin
            if (i == 0) chk("bit_count_at_bit_start", 32'(bit_count), 32'(exp_bc));
            chk("strobe_position", 32'(sample_valid), 32'(i == h + 2));
            if (sample_valid) strobes++;
            if (i == h + 2) chk("voted_bit", 32'(sampled_bit), 32'(exp_bit));
            if (i == pq - 1) chk("voted_bit_held", 32'(sampled_bit), 32'(exp_bit));
            RX_IN = (i == h - 1) ? r0 : (i == h) ? r1 : (i == h + 1) ? r2 : rest;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; RX_IN = 1'b1; Prescale = 6'd8;
        counter_enable = 1'b0; data_sample_en = 1'b0;
        ticks(2);
        chk("rst_edge_count", 32'(edge_count), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd1);
        chk("rst_sampled_bit", 32'(sampled_bit), 32'd1);
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_prescale_err", 32'(prescale_err), 32'd0);
        rst = 1'b0;
        tick();

        // Free-running counters at prescale 8 for three bit periods.
        counter_enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            chk("p8_edge_count", 32'(edge_count), 32'(i % 8));
            chk("p8_bit_count", 32'(bit_count), 32'(1 + i / 8));
            chk("p8_no_strobe", 32'(sample_valid), 32'd0);
            if (i == 23) counter_enable = 1'b0;
            tick();
        end
        chk("drop_edge_count", 32'(edge_count), 32'd0);
        chk("drop_bit_count", 32'(bit_count), 32'd1);

        // Prescale 16, line low across edges 7..9.
        Prescale = 6'd16;
        tick();
        counter_enable = 1'b1; data_sample_en = 1'b1;
        bit_cycle(16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        chk("p16_next_bit", 32'(bit_count), 32'd2);
        counter_enable = 1'b0; data_sample_en = 1'b0; RX_IN = 1'b1;
        tick();

        // Glitch rejection at prescale 8.
        Prescale = 6'd8;
        tick();
        counter_enable = 1'b1; data_sample_en = 1'b1;
        bit_cycle(8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        bit_cycle(8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);

        // Sampling disabled at one vote edge: no strobe, bit held.
        for (int i = 0; i < 8; i++) begin
            data_sample_en = (i != 4);
            RX_IN = 1'b1;
            chk("gap_no_strobe", 32'(sample_valid), 32'd0);
            tick();
        end
        chk("gap_bit_held", 32'(sampled_bit), 32'd0);

        // data_sample_en without counter_enable never samples.
        counter_enable = 1'b0; data_sample_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_no_strobe", 32'(sample_valid), 32'd0);
            chk("idle_edge_count", 32'(edge_count), 32'd0);
        end

        // 8N1 frame 0xA5 LSB-first at prescale 32.
        Prescale = 6'd32;
        tick();
        frame_bits = {1'b1, 8'hA5, 1'b0};
        counter_enable = 1'b1; data_sample_en = 1'b1;
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            bit_cycle(32, frame_bits[k], frame_bits[k], frame_bits[k], frame_bits[k],
                      frame_bits[k], k + 1);
        end
        chk("frame_strobe_count", 32'(strobes), 32'd10);
        chk("frame_bit_count_end", 32'(bit_count), 32'd11);
        counter_enable = 1'b0; data_sample_en = 1'b0; RX_IN = 1'b1;
        tick();

        // Prescale frozen while counting; illegal value falls back to 8.
        Prescale = 6'd8;
        tick();
        counter_enable = 1'b1;
        ticks(3);
        Prescale = 6'd16;
        ticks(4);
        chk("frozen_edge7", 32'(edge_count), 32'd7);
        tick();
        chk("frozen_wrap", 32'(edge_count), 32'd0);
        chk("frozen_bit", 32'(bit_count), 32'd2);
        counter_enable = 1'b0;
        tick();
        counter_enable = 1'b1;
        ticks(15);
        chk("p16_edge15", 32'(edge_count), 32'd15);
        tick();
        chk("p16_wrap", 32'(edge_count), 32'd0);
        Prescale = 6'd12;
        tick();
        chk("err_frozen", 32'(prescale_err), 32'd0);
        counter_enable = 1'b0;
        tick();
        chk("err_illegal", 32'(prescale_err), 32'd1);
        counter_enable = 1'b1;
        ticks(7);
        chk("illegal_edge7", 32'(edge_count), 32'd7);
        tick();
        chk("illegal_wrap8", 32'(edge_count), 32'd0);
        counter_enable = 1'b0;
        tick();

        // Reset mid-frame at edge 5 of bit 4 while a vote is pending.
        counter_enable = 1'b1; data_sample_en = 1'b1; RX_IN = 1'b0;
        ticks(29);
        chk("pre_rst_edge", 32'(edge_count), 32'd5);
        chk("pre_rst_bit", 32'(bit_count), 32'd4);
        chk("pre_rst_sampled", 32'(sampled_bit), 32'd0);
        chk("pre_rst_err", 32'(prescale_err), 32'd1);
        rst = 1'b1; Prescale = 6'd8;
        tick();
        chk("mid_rst_edge", 32'(edge_count), 32'd0);
        chk("mid_rst_bit", 32'(bit_count), 32'd1);
        chk("mid_rst_sampled", 32'(sampled_bit), 32'd1);
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_err", 32'(prescale_err), 32'd0);
        rst = 1'b0; counter_enable = 1'b0; data_sample_en = 1'b0; RX_IN = 1'b1;
        tick();
        chk("post_rst_valid", 32'(sample_valid), 32'd0);
        chk("post_rst_err", 32'(prescale_err), 32'd0);
        tick();
        chk("post_rst_valid2", 32'(sample_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
